// File: rtl/mips_run_monitor.sv
// Reset sequencer and run monitor for the MIPS core: releases core reset after a hold,
// counts RUN cycles/stores and reports pass, bad store, timeout (and stall if MIPS_MON_STALL_DETECT_EN).
module mips_run_monitor #(
    parameter int WIDTH        = 32,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1000,
    parameter int PASS_ADDR    = 84,
    parameter int PASS_DATA    = 7,
    parameter int STALL_CYCLES = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             core_reset,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t            state_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic run_s;
    logic store_s;
    logic addr_hit_s;
    logic pass_hit_s;
    logic bad_hit_s;
    logic stall_hit_s;
    logic timeout_hit_s;

    // Decode this cycle's RUN events; everything is gated so core inputs only matter in RUN
    always_comb begin
        run_s         = (state_r == ST_RUN);
        store_s       = run_s && memwrite;
        addr_hit_s    = store_s && (dataadr == WIDTH'(PASS_ADDR));
        pass_hit_s    = addr_hit_s && (writedata == WIDTH'(PASS_DATA));
        bad_hit_s     = addr_hit_s && (writedata != WIDTH'(PASS_DATA));
        timeout_hit_s = run_s && (cycle_count == CNT_W'(TIMEOUT - 1));
    end

`ifdef MIPS_MON_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    logic [WIDTH-1:0]   prev_pc_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic               pc_same_s;

    assign pc_same_s   = (pc == prev_pc_r);
    assign stall_hit_s = run_s && pc_same_s && (stall_cnt_r == STALL_W'(STALL_CYCLES - 1));

    // Track how long pc has sat still; the count only accumulates while running
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_pc_r   <= {WIDTH{1'b0}};
            stall_cnt_r <= {STALL_W{1'b0}};
        end else begin
            prev_pc_r <= pc;
            if (run_s && pc_same_s) begin
                if (stall_cnt_r != STALL_W'(STALL_CYCLES - 1)) begin
                    stall_cnt_r <= stall_cnt_r + STALL_W'(1);
                end else begin
                    stall_cnt_r <= stall_cnt_r;
                end
            end else begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end
        end
    end
`else
    logic unused_stall_s;

    // Without stall detection pc and STALL_CYCLES have no function; fold them into a sink
    assign unused_stall_s = ^{pc, 32'(STALL_CYCLES)};
    assign stall_hit_s    = 1'b0;
`endif

    // Sequencer FSM with all reported outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HOLD;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            core_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 2'd0;
            cycle_count <= {CNT_W{1'b0}};
            store_count <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_W'(RESET_CYCLES)) begin
                        state_r    <= ST_RUN;
                        core_reset <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        core_reset <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cycle_count != {CNT_W{1'b1}}) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end else begin
                        cycle_count <= cycle_count;
                    end
                    if (store_s) begin
                        store_count <= store_count + CNT_W'(1);
                    end else begin
                        store_count <= store_count;
                    end
                    // Store outcome beats stall, stall beats timeout
                    if (pass_hit_s) begin
                        state_r <= ST_PASS;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                    end else if (bad_hit_s) begin
                        state_r   <= ST_FAIL;
                        done      <= 1'b1;
                        fail_code <= 2'd1;
                    end else if (stall_hit_s) begin
                        state_r   <= ST_FAIL;
                        done      <= 1'b1;
                        fail_code <= 2'd3;
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_TIMEOUT;
                        done      <= 1'b1;
                        fail_code <= 2'd2;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    // Terminal: core keeps running, verdict and counters frozen
                    core_reset <= 1'b0;
                end
                default: begin
                    state_r    <= ST_HOLD;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed self-checking bench for mips_run_monitor (TIMEOUT=20); stall expectations follow
// whether MIPS_MON_STALL_DETECT_EN is defined.
module tb_mips_run_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        core_reset;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] store_count;

    int checks = 0;
    int errors = 0;
    bit pc_freeze = 1'b0;

    mips_run_monitor #(
        .WIDTH(32), .RESET_CYCLES(2), .TIMEOUT(20), .PASS_ADDR(84),
        .PASS_DATA(7), .STALL_CYCLES(8), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .core_reset(core_reset), .done(done), .pass(pass),
        .fail_code(fail_code), .cycle_count(cycle_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!pc_freeze) pc = pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic cr, input logic dn, input logic ps,
                            input logic [1:0] fc, input logic [31:0] cc, input logic [31:0] sc);
        chk({tag, ".core_reset"}, 64'(core_reset), 64'(cr));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".pass"}, 64'(pass), 64'(ps));
        chk({tag, ".fail_code"}, 64'(fail_code), 64'(fc));
        chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
        chk({tag, ".store_count"}, 64'(store_count), 64'(sc));
    endtask

    // One reset cycle, then release; returns positioned at the start of RUN cycle 1
    task automatic restart();
        memwrite = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        reset = 1'b1; pc = 32'h0; memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0;
        tick(2);
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        // Reset sequencing: core_reset falls at the second edge after E0
        reset = 1'b0;
        tick(1);
        chk("seq.e0", 64'(core_reset), 64'd1);
        tick(1);
        chk("seq.e1", 64'(core_reset), 64'd1);
        tick(1);
        chk_outs("seq.e2", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        // Pass store in RUN cycle 5, later stores ignored
        tick(4);
        chk("pass.pre_cc", 64'(cycle_count), 64'd4);
        memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
        tick(1);
        chk_outs("pass", 1'b0, 1'b1, 1'b1, 2'd0, 32'd5, 32'd1);
        writedata = 32'd6;
        tick(2);
        memwrite = 1'b0;
        tick(1);
        chk_outs("pass.frozen", 1'b0, 1'b1, 1'b1, 2'd0, 32'd5, 32'd1);

        // Bad store after an ordinary store
        restart();
        chk_outs("bad.start", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        memwrite = 1'b1; dataadr = 32'd80; writedata = 32'd3;
        tick(1);
        chk_outs("bad.first", 1'b0, 1'b0, 1'b0, 2'd0, 32'd1, 32'd1);
        dataadr = 32'd84; writedata = 32'd6;
        tick(1);
        memwrite = 1'b0;
        chk_outs("bad", 1'b0, 1'b1, 1'b0, 2'd1, 32'd2, 32'd2);

        // Mid-run reset at RUN cycle 10, then a full timeout run
        restart();
        tick(9);
        chk("mid.cc", 64'(cycle_count), 64'd9);
        reset = 1'b1;
        tick(1);
        chk_outs("mid.reset", 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        reset = 1'b0;
        tick(2);
        chk("mid.hold", 64'(core_reset), 64'd1);
        tick(1);
        chk_outs("mid.run", 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tick(19);
        chk_outs("tmo.pre", 1'b0, 1'b0, 1'b0, 2'd0, 32'd19, 32'd0);
        tick(1);
        chk_outs("tmo", 1'b0, 1'b1, 1'b0, 2'd2, 32'd20, 32'd0);
        tick(2);
        chk_outs("tmo.frozen", 1'b0, 1'b1, 1'b0, 2'd2, 32'd20, 32'd0);

        // Pass store on RUN cycle 20 wins over timeout
        restart();
        tick(19);
        memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
        tick(1);
        memwrite = 1'b0;
        chk_outs("tmo.pass", 1'b0, 1'b1, 1'b1, 2'd0, 32'd20, 32'd1);

        // Frozen pc: stall fault when enabled, otherwise plain timeout
        pc_freeze = 1'b1;
        pc = 32'h1C;
        restart();
`ifdef MIPS_MON_STALL_DETECT_EN
        tick(7);
        chk("stall.pre", 64'(done), 64'd0);
        tick(1);
        chk_outs("stall", 1'b0, 1'b1, 1'b0, 2'd3, 32'd8, 32'd0);
`else
        tick(19);
        chk("stall.pre", 64'(done), 64'd0);
        tick(1);
        chk_outs("stall", 1'b0, 1'b1, 1'b0, 2'd2, 32'd20, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_run_monitor.md
# mips_run_monitor

Synthesizable reset sequencer and run monitor for the MIPS `top` under test. It replaces ad-hoc clock/reset handling in benches. It releases the core from reset after a programmable hold and counts execution cycles. It watches the data-memory write port and declares pass, fail or timeout. It sits beside `top`, driven by the bench's `clk`/`reset`, and feeds the core's reset input from `core_reset`.

## Interface
Parameters:
- WIDTH, 32, datapath width of `pc`, `dataadr`, `writedata`
- RESET_CYCLES, 2, cycles `core_reset` stays high after `reset` falls (≥1)
- TIMEOUT, 1000, max RUN cycles before timeout (≥2)
- PASS_ADDR, 84, store address that signals end of test
- PASS_DATA, 7, value that must be stored to PASS_ADDR for pass
- STALL_CYCLES, 8, consecutive unchanged-`pc` cycles counted as a hang (stall option only)
- CNT_W, 32, width of `cycle_count` and `store_count`

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- pc  in  WIDTH  core program counter
- memwrite  in  1  core data-memory write enable
- dataadr  in  WIDTH  core data-memory address
- writedata  in  WIDTH  core store data
- core_reset  out  1  reset to the core, registered
- done  out  1  run finished (sticky)
- pass  out  1  test passed (sticky, only with `done`)
- fail_code  out  2  0 none, 1 bad store, 2 timeout, 3 stall
- cycle_count  out  CNT_W  RUN cycles elapsed
- store_count  out  CNT_W  stores observed in RUN

## Operation
- Reset values: core_reset=1, done=0, pass=0, fail_code=0, cycle_count=0, store_count=0, FSM=HOLD, hold counter=0.
- FSM states: HOLD → RUN → one of PASS / FAIL / TIMEOUT. Terminal states hold until `reset`.
- HOLD: the hold counter increments each cycle. After RESET_CYCLES cycles with reset=0, the FSM enters RUN and core_reset goes 0.
- RUN: cycle_count increments once per cycle and saturates at all-ones. Core inputs are sampled only in RUN.
- RUN store events: on each cycle with memwrite=1, store_count increments.
  - Store with dataadr==PASS_ADDR and writedata==PASS_DATA → PASS: done=1, pass=1.
  - Store with dataadr==PASS_ADDR and writedata!=PASS_DATA → FAIL: done=1, fail_code=1.
  - Stores to other addresses are counted only.
- Timeout: in RUN, with cycle_count==TIMEOUT-1 and no terminal event this cycle → TIMEOUT: done=1, fail_code=2.
- Priority within one cycle: pass/bad-store > stall > timeout.
- In terminal states:
  - cycle_count and store_count freeze.
  - core_reset stays 0, so the core free-runs and final memory stays inspectable.
  - Core inputs are ignored.
- `reset` mid-run: the next edge returns to reset values and HOLD regardless of state. core_reset reasserts on that edge.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `reset` falls before edge E0. core_reset is 1 through edge E0+RESET_CYCLES-1 and is 0 after edge E0+RESET_CYCLES.
- A store in RUN cycle n is reflected in done/pass/fail_code/store_count after the same edge (1-cycle latency).
- Timeout: done rises at the edge ending RUN cycle TIMEOUT. At that point cycle_count==TIMEOUT.

## Configuration
- `MIPS_MON_STALL_DETECT_EN` defined:
  - Adds a previous-pc register and a stall counter. The counter resets to 0 whenever pc differs from the previous pc or the FSM is outside RUN.
  - When the counter reaches STALL_CYCLES-1 with pc unchanged → FAIL, fail_code=3.
- Not defined: the stall logic and parameter use are absent, and fail_code never takes value 3.

## Test plan
- Reset sequencing: hold reset 2 cycles, then drop; RESET_CYCLES=2 → core_reset falls exactly 2 edges after release; cycle_count=0 at that point.
- Pass store: in RUN cycle 5, memwrite=1, dataadr=84, writedata=7 → next edge done=1, pass=1, fail_code=0, store_count=1; later inputs change nothing.
- Bad store: stores to addr 80 (data 3), then addr 84 (data 6) → store_count=2, done=1, pass=0, fail_code=1.
- Timeout: TIMEOUT=20, memwrite=0 always → done=1, fail_code=2 at the edge where cycle_count==20; simultaneous pass store on cycle 20 instead gives pass=1.
- Mid-run reset: assert reset for 1 cycle at RUN cycle 10 → all outputs return to reset values; second run behaves identically to the first.
- Stall (macro defined, STALL_CYCLES=8): pc held at 0x1C → fail_code=3 after 8 unchanged cycles; with macro undefined, the same stimulus ends in timeout (fail_code=2).
